cpu_run_controller: RTL and testbench

- Sequences CPU execution by generating a one-cycle `cpu_step_en` strobe. Each strobe gates exactly one PC/datapath advance.
- Supports four modes: free-run, single-step, breakpoint-on-PC, and HALT.
- Inputs: two raw buttons, a breakpoint switch/address, the current PC, `HALT_flag`, and `cpu_paused` from the instruction loader.
- Sits between the board I/O, the instruction loader and the program counter enable. Replaces the free-running PC enable with a controlled one.

---
 rtl/cpu_run_controller_if.sv | 39 +++
 rtl/cpu_run_controller.sv | 158 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if
// Board-side and CPU-side signals of the run controller, bundled for port use.
//   run_btn, step_btn   raw push buttons (asynchronous)
//   tick                one-cycle pacing strobe at the execution rate
//   bp_en, bp_addr      breakpoint enable and breakpoint PC value
//   pc_addr             current program counter
//   HALT_flag           HALT instruction decoded at the current PC
//   cpu_paused          instruction loader owns iRAM/PC
//   cpu_step_en         one-cycle advance strobe to the CPU
//   run_state           00 STOPPED, 01 RUNNING, 10 STEP, 11 HALTED
//   bp_hit              sticky: breakpoint caused the last stop
//   instr_count         saturating count of issued strobes
// master: drives the inputs (board/loader/CPU side); slave: the controller.
interface cpu_run_controller_if #(
   parameter int CNT_W = 16
);
   logic             run_btn;
   logic             step_btn;
   logic             tick;
   logic             bp_en;
   logic [7:0]       bp_addr;
   logic [7:0]       pc_addr;
   logic             HALT_flag;
   logic             cpu_paused;
   logic             cpu_step_en;
   logic [1:0]       run_state;
   logic             bp_hit;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output run_btn, step_btn, tick, bp_en, bp_addr, pc_addr, HALT_flag, cpu_paused,
      input  cpu_step_en, run_state, bp_hit, instr_count
   );

   modport slave (
      input  run_btn, step_btn, tick, bp_en, bp_addr, pc_addr, HALT_flag, cpu_paused,
      output cpu_step_en, run_state, bp_hit, instr_count
   );
endinterface

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Gates CPU execution with a registered one-cycle cpu_step_en strobe.
// Modes: free-run on tick, single step, breakpoint-on-PC and HALT.
// Ports:
//   clk   system clock (single domain)
//   rst   synchronous, active-high reset
//   bus   cpu_run_controller_if.slave: buttons, tick, breakpoint, PC, HALT,
//         loader pause in; step strobe, run state, bp_hit, instr_count out
module cpu_run_controller #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 16
) (
   input logic                  clk,
   input logic                  rst,
   cpu_run_controller_if.slave  bus
);
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_STOPPED = 2'b00,
      ST_RUNNING = 2'b01,
      ST_STEP    = 2'b10,
      ST_HALTED  = 2'b11
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // index 0 = run button, index 1 = step button
   logic [1:0]      raw;
   logic [1:0]      sync_p0;
   logic [1:0]      sync_p1;
   logic [1:0]      deb;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt [2];

   state_t           state, state_n;
   logic             step_en, step_en_n;
   logic             skip, skip_n;
   logic             bp_hit, bp_hit_n;
   logic             cnt_clr;
   logic [CNT_W-1:0] count;
   logic             run_press, step_press, bp_match;

   assign raw = {bus.step_btn, bus.run_btn};

   // Stage p0/p1: two-flop synchronizer, then debounce with press detect
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         deb     <= '0;
         press   <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync_p1[i] != deb[i]) begin
               // accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle
               if (db_cnt[i] == DB_LAST) begin
                  deb[i]    <= sync_p1[i];
                  db_cnt[i] <= '0;
                  press[i]  <= sync_p1[i];
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // run beats step when both pulse together
   assign run_press  = press[0];
   assign step_press = press[1] & ~press[0];
   assign bp_match   = bus.bp_en && (bus.pc_addr == bus.bp_addr) && !skip;

   // Stage p2: mode control; the strobe is registered from this decision
   always_comb begin
      state_n   = state;
      step_en_n = 1'b0;
      skip_n    = skip;
      bp_hit_n  = bp_hit;
      cnt_clr   = 1'b0;
      if (bus.cpu_paused) begin
         state_n  = ST_STOPPED;
         bp_hit_n = 1'b0;
         skip_n   = 1'b0;
         cnt_clr  = 1'b1;
      end else if (bus.HALT_flag) begin
         state_n = ST_HALTED;
      end else begin
         case (state)
            ST_STOPPED: begin
               if (run_press) begin
                  state_n  = ST_RUNNING;
                  skip_n   = 1'b1;
                  bp_hit_n = 1'b0;
               end else if (step_press) begin
                  state_n  = ST_STEP;
                  bp_hit_n = 1'b0;
               end
            end
            ST_RUNNING: begin
               if (bus.tick && bp_match) begin
                  state_n  = ST_STOPPED;
                  bp_hit_n = 1'b1;
               end else if (run_press) begin
                  state_n = ST_STOPPED;
               end else if (bus.tick && !step_en) begin
                  // a tick landing on a live strobe is dropped, keeping strobes apart
                  step_en_n = 1'b1;
                  skip_n    = 1'b0;
               end
            end
            ST_STEP: begin
               if (bus.tick && !step_en) begin
                  step_en_n = 1'b1;
                  state_n   = ST_STOPPED;
               end
            end
            ST_HALTED: begin
               state_n = ST_STOPPED;
            end
            default: state_n = ST_STOPPED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_STOPPED;
         step_en <= 1'b0;
         skip    <= 1'b0;
         bp_hit  <= 1'b0;
         count   <= '0;
      end else begin
         state   <= state_n;
         step_en <= step_en_n;
         skip    <= skip_n;
         bp_hit  <= bp_hit_n;
         if (cnt_clr)
            count <= '0;
         else if (step_en)
            count <= sat_inc(count);
      end
   end

   assign bus.cpu_step_en = step_en;
   assign bus.run_state   = state;
   assign bus.bp_hit      = bp_hit;
   assign bus.instr_count = count;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller
// Directed bench for cpu_run_controller with DEBOUNCE_CYCLES=4, CNT_W=4 and
// a tick every 8 clocks. Inputs change and outputs are sampled on negedge.
module tb_cpu_run_controller;
   localparam int DB = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cpu_run_controller_if #(.CNT_W(CW)) bus ();

   cpu_run_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         tests = 0;
   int         fails = 0;
   logic       tick_en = 1'b0;
   int         tcnt = 0;
   int         strobe_cnt = 0;
   int         double_cnt = 0;
   logic       prev_en = 1'b0;
   logic [7:0] pc_base = 8'd0;
   int         s0;

   // PC model: advances at the end of every strobe cycle
   assign bus.pc_addr = pc_base + strobe_cnt[7:0];

   always @(posedge clk) begin
      if (bus.cpu_step_en === 1'b1) strobe_cnt <= strobe_cnt + 1;
      if (bus.cpu_step_en === 1'b1 && prev_en) double_cnt <= double_cnt + 1;
      prev_en <= (bus.cpu_step_en === 1'b1);
   end

   task automatic cyc();
      @(negedge clk);
      if (tick_en) begin
         tcnt     = (tcnt == 7) ? 0 : tcnt + 1;
         bus.tick = (tcnt == 7);
      end else begin
         tcnt     = 0;
         bus.tick = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      logic got;
      got = 1'b0;
      for (int i = 0; i < 16 && !got; i++) begin
         cyc();
         if (bus.tick) got = 1'b1;
      end
      chk("tick_seen", 32'(got), 32'd1);
   endtask

   // optional 1-cycle bounces, 10-cycle hold, then release and settle
   task automatic press(input logic r, input logic s, input int bounce);
      for (int i = 0; i < bounce; i++) begin
         bus.run_btn = r; bus.step_btn = s; cyc();
         bus.run_btn = 1'b0; bus.step_btn = 1'b0; cyc();
      end
      bus.run_btn = r; bus.step_btn = s;
      repeat (10) cyc();
      bus.run_btn = 1'b0; bus.step_btn = 1'b0;
      repeat (12) cyc();
   endtask

   initial begin
      rst = 1'b1;
      bus.run_btn = 1'b0; bus.step_btn = 1'b0; bus.tick = 1'b0;
      bus.bp_en = 1'b1; bus.bp_addr = 8'h05;
      bus.HALT_flag = 1'b0; bus.cpu_paused = 1'b0;
      repeat (3) cyc();
      chk("rst_state", 32'(bus.run_state), 32'd0);
      chk("rst_en", 32'(bus.cpu_step_en), 32'd0);
      chk("rst_bp", 32'(bus.bp_hit), 32'd0);
      chk("rst_cnt", 32'(bus.instr_count), 32'd0);
      rst = 1'b0;
      cyc();

      // bounced run press -> one press, RUNNING
      press(1'b1, 1'b0, 2);
      chk("run_state", 32'(bus.run_state), 32'd1);
      chk("run_cnt0", 32'(bus.instr_count), 32'd0);
      tick_en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         wait_tick();
         cyc();
         chk("run_strobe", 32'(bus.cpu_step_en), 32'd1);
         cyc();
         chk("run_strobe_off", 32'(bus.cpu_step_en), 32'd0);
         chk("run_cnt", 32'(bus.instr_count), 32'(k));
      end
      // PC is now 5: breakpoint on the next tick
      wait_tick();
      cyc();
      chk("bp_no_strobe", 32'(bus.cpu_step_en), 32'd0);
      chk("bp_state", 32'(bus.run_state), 32'd0);
      chk("bp_hit", 32'(bus.bp_hit), 32'd1);
      chk("bp_cnt", 32'(bus.instr_count), 32'd5);

      // resume skips the breakpoint once
      tick_en = 1'b0;
      press(1'b1, 1'b0, 0);
      chk("resume_state", 32'(bus.run_state), 32'd1);
      chk("resume_bp_clr", 32'(bus.bp_hit), 32'd0);
      tick_en = 1'b1;
      wait_tick();
      cyc();
      chk("resume_skip_strobe", 32'(bus.cpu_step_en), 32'd1);
      cyc();
      chk("resume_cnt", 32'(bus.instr_count), 32'd6);
      pc_base = 8'(5 - strobe_cnt);
      wait_tick();
      cyc();
      chk("rearm_no_strobe", 32'(bus.cpu_step_en), 32'd0);
      chk("rearm_state", 32'(bus.run_state), 32'd0);
      chk("rearm_bp_hit", 32'(bus.bp_hit), 32'd1);

      // loader pause clears count and bp_hit
      tick_en = 1'b0;
      bus.cpu_paused = 1'b1;
      cyc();
      bus.cpu_paused = 1'b0;
      chk("pause_state", 32'(bus.run_state), 32'd0);
      chk("pause_cnt", 32'(bus.instr_count), 32'd0);
      chk("pause_bp", 32'(bus.bp_hit), 32'd0);

      // three single steps at the breakpoint PC (not checked in STEP)
      for (int k = 0; k < 3; k++) begin
         tick_en = 1'b0;
         press(1'b0, 1'b1, 0);
         chk("step_state", 32'(bus.run_state), 32'd2);
         tick_en = 1'b1;
         wait_tick();
         cyc();
         chk("step_strobe", 32'(bus.cpu_step_en), 32'd1);
         chk("step_done", 32'(bus.run_state), 32'd0);
         cyc();
      end
      chk("step_cnt", 32'(bus.instr_count), 32'd3);

      // HALT while running
      tick_en = 1'b0;
      bus.bp_en = 1'b0;
      press(1'b1, 1'b0, 0);
      chk("halt_pre_run", 32'(bus.run_state), 32'd1);
      tick_en = 1'b1;
      wait_tick();
      cyc();
      chk("halt_pre_strobe", 32'(bus.cpu_step_en), 32'd1);
      cyc();
      bus.HALT_flag = 1'b1;
      s0 = strobe_cnt;
      cyc();
      chk("halt_state", 32'(bus.run_state), 32'd3);
      press(1'b1, 1'b0, 0);
      press(1'b0, 1'b1, 0);
      repeat (6) cyc();
      chk("halt_no_strobes", 32'(strobe_cnt), 32'(s0));
      chk("halt_hold", 32'(bus.run_state), 32'd3);
      bus.HALT_flag = 1'b0;
      cyc();
      chk("halt_release", 32'(bus.run_state), 32'd0);

      // saturation: 4 + 21 strobes clamps at 15
      tick_en = 1'b0;
      press(1'b1, 1'b0, 0);
      tick_en = 1'b1;
      repeat (170) cyc();
      chk("sat_cnt", 32'(bus.instr_count), 32'd15);
      chk("sat_state", 32'(bus.run_state), 32'd1);

      // run press stops; then reset in the middle of STEP
      tick_en = 1'b0;
      press(1'b1, 1'b0, 0);
      chk("stop_state", 32'(bus.run_state), 32'd0);
      press(1'b0, 1'b1, 0);
      chk("mid_step_state", 32'(bus.run_state), 32'd2);
      s0 = strobe_cnt;
      rst = 1'b1;
      tick_en = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst2_state", 32'(bus.run_state), 32'd0);
      chk("rst2_en", 32'(bus.cpu_step_en), 32'd0);
      chk("rst2_cnt", 32'(bus.instr_count), 32'd0);
      chk("rst2_bp", 32'(bus.bp_hit), 32'd0);
      repeat (20) cyc();
      chk("rst2_no_strobe", 32'(strobe_cnt), 32'(s0));
      chk("rst2_idle", 32'(bus.run_state), 32'd0);

      // simultaneous run+step -> RUNNING
      tick_en = 1'b0;
      press(1'b1, 1'b1, 0);
      chk("both_run_wins", 32'(bus.run_state), 32'd1);

      // 3-cycle glitch is shorter than the debounce window
      bus.run_btn = 1'b1;
      repeat (3) cyc();
      bus.run_btn = 1'b0;
      repeat (12) cyc();
      chk("glitch_ignored", 32'(bus.run_state), 32'd1);

      chk("no_double_strobe", 32'(double_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
